// File: rtl/wb_write_scheduler_if.sv
// Writeback scheduler bus: pipeline/secondary write requests, OUT handshake, RF write port.
interface wb_write_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              sec_we;
  logic [ADDR_W-1:0] sec_rd;
  logic [DATA_W-1:0] sec_data;
  logic              out_en;
  logic              out_ack;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              stall;

  modport master (
    output wb_we, wb_rd, wb_data, sec_we, sec_rd, sec_data, out_en, out_ack,
    input  rf_we, rf_addr, rf_data, out_port, out_valid, stall
  );
  modport slave (
    input  wb_we, wb_rd, wb_data, sec_we, sec_rd, sec_data, out_en, out_ack,
    output rf_we, rf_addr, rf_data, out_port, out_valid, stall
  );
endinterface

// File: rtl/wb_write_scheduler.sv
// Writeback resource scheduler: RF write port arbitration with secondary-write FIFO and OUT port.
// Optional WB_BYPASS_EN: a secondary write with an empty FIFO and idle WB goes straight to the RF.
module wb_write_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_write_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef enum logic {IDLE, PRESENT} ost_t;

  wr_t             mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  ost_t            ost;

  logic wbv, secv, oute, bypass, push, pop;
  wr_t  head;

  // Stall masks every request input; the FIFO keeps draining underneath it.
  assign bus.stall = (cnt >= CW'(DEPTH - 1)) | ((ost == PRESENT) & bus.out_en & ~bus.out_ack);
  assign wbv  = bus.wb_we  & ~bus.stall;
  assign secv = bus.sec_we & ~bus.stall;
  assign oute = bus.out_en & ~bus.stall;

`ifdef WB_BYPASS_EN
  assign bypass = secv & ~wbv & (cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = secv & ~bypass;
  assign pop  = ~wbv & (cnt != '0);
  assign head = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      bus.rf_we <= 1'b0;
      if (wbv) begin
        bus.rf_we   <= 1'b1;
        bus.rf_addr <= bus.wb_rd;
        bus.rf_data <= bus.wb_data;
      end else if (pop) begin
        // Killed heads still pop, but leave the port idle.
        if (ent_vld[rp]) begin
          bus.rf_we   <= 1'b1;
          bus.rf_addr <= head.rd;
          bus.rf_data <= head.data;
        end
      end else if (bypass) begin
        bus.rf_we   <= 1'b1;
        bus.rf_addr <= bus.sec_rd;
        bus.rf_data <= bus.sec_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      // A WB write is younger than anything queued, so it supersedes same-rd entries.
      for (int i = 0; i < DEPTH; i++)
        if (wbv && mem[i].rd == bus.wb_rd) ent_vld[i] <= 1'b0;
      if (pop) begin
        ent_vld[rp] <= 1'b0;
        rp          <= PW'(rp + 1'b1);
      end
      // Same-cycle sec push is younger than the WB write: it survives the kill above.
      if (push) begin
        ent_vld[wp] <= 1'b1;
        wp          <= PW'(wp + 1'b1);
      end
      case ({push, pop})
        2'b10:   cnt <= CW'(cnt + 1'b1);
        2'b01:   cnt <= CW'(cnt - 1'b1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{rd: bus.sec_rd, data: bus.sec_data};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && cnt == CW'(DEPTH)))
      else $error("secondary-write FIFO overflow");
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ost           <= IDLE;
      bus.out_port  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (ost)
        IDLE: if (oute) begin
          ost           <= PRESENT;
          bus.out_port  <= bus.wb_data;
          bus.out_valid <= 1'b1;
        end
        PRESENT: if (bus.out_ack) begin
          if (oute) bus.out_port <= bus.wb_data;
          else begin
            ost           <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: ost <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed + random check of wb_write_scheduler against a queue-based reference model.
module tb_wb_write_scheduler;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    bit                ok;
  } ent_t;

  ent_t              q[$];
  bit                m_present;
  logic [DATA_W-1:0] m_port;
  bit                m_rfwe;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_present = 0; m_port = '0;
    m_rfwe = 0; m_addr = '0; m_data = '0;
  endtask

  // One clock: drive at negedge, check stall, advance model, check registered outputs next negedge.
  task automatic cyc(input bit we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                     input bit swe, input logic [ADDR_W-1:0] srd, input logic [DATA_W-1:0] sd,
                     input bit oe, input bit ack);
    bit st, wbv, secv, oute;
    int n0;
    ent_t e;
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = d;
    bus.sec_we = swe; bus.sec_rd = srd; bus.sec_data = sd;
    bus.out_en = oe; bus.out_ack = ack;
    #1;
    st = (q.size() >= DEPTH - 1) || (m_present && oe && !ack);
    chk("stall", bus.stall, st);
    wbv = we && !st; secv = swe && !st; oute = oe && !st;
    n0 = q.size();
    m_rfwe = 0;
    if (wbv) begin
      m_rfwe = 1; m_addr = rd; m_data = d;
      foreach (q[i]) if (q[i].rd == rd) q[i].ok = 0;
    end else if (n0 > 0) begin
      e = q.pop_front();
      if (e.ok) begin m_rfwe = 1; m_addr = e.rd; m_data = e.data; end
    end
    if (secv) begin
`ifdef WB_BYPASS_EN
      if (n0 == 0 && !wbv) begin m_rfwe = 1; m_addr = srd; m_data = sd; end
      else q.push_back('{rd: srd, data: sd, ok: 1'b1});
`else
      q.push_back('{rd: srd, data: sd, ok: 1'b1});
`endif
    end
    if (m_present) begin
      if (ack) begin
        if (oute) m_port = d;
        else m_present = 0;
      end
    end else if (oute) begin
      m_present = 1; m_port = d;
    end
    @(negedge clk);
    chk("rf_we", bus.rf_we, m_rfwe);
    chk("rf_addr", bus.rf_addr, m_addr);
    chk("rf_data", bus.rf_data, m_data);
    chk("out_valid", bus.out_valid, m_present);
    chk("out_port", bus.out_port, m_port);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rf_we"}, bus.rf_we, 0);
    chk({tag, "_rf_addr"}, bus.rf_addr, 0);
    chk({tag, "_rf_data"}, bus.rf_data, 0);
    chk({tag, "_out_port"}, bus.out_port, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_stall"}, bus.stall, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wb_we = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.sec_we = 0; bus.sec_rd = '0; bus.sec_data = '0;
    bus.out_en = 0; bus.out_ack = 0;
    model_reset();
    rst_n = 1'b1;
    mid_reset("rst0");

    // WB and secondary in the same cycle: WB first, secondary one cycle later
    cyc(1, 3, 16'h1234, 1, 5, 16'hBEEF, 0, 0);
    chk("r3_we", bus.rf_we, 1);
    chk("r3_addr", bus.rf_addr, 3);
    chk("r3_data", bus.rf_data, 16'h1234);
    idle(1);
    chk("r5_addr", bus.rf_addr, 5);
    chk("r5_data", bus.rf_data, 16'hBEEF);

    // Queued R2 superseded by a later WB write to R2
    cyc(1, 0, 16'h1111, 1, 2, 16'h0001, 0, 0);
    cyc(1, 2, 16'h0002, 0, 0, 0, 0, 0);
    chk("kill_wb_data", bus.rf_data, 16'h0002);
    idle(1);
    chk("kill_no_write", bus.rf_we, 0);
    chk("kill_hold_data", bus.rf_data, 16'h0002);

    // Fill the FIFO until stall rises, then drain
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'(i), 1, 3'(4 + i), 16'(16'h100 + i), 0, 0);
    chk("fill_stall", bus.stall, 1);
    cyc(1, 1, 16'hDEAD, 1, 7, 16'hCAFE, 0, 0);
    idle(4);
    chk("drain_stall", bus.stall, 0);

    // OUT back-to-back: second out_en stalls until ack
    cyc(0, 0, 16'h00AA, 0, 0, 0, 1, 0);
    chk("out_aa_valid", bus.out_valid, 1);
    chk("out_aa_port", bus.out_port, 16'h00AA);
    cyc(0, 0, 16'h00BB, 0, 0, 0, 1, 0);
    chk("out_bb_held", bus.out_port, 16'h00AA);
    cyc(0, 0, 16'h00BB, 0, 0, 0, 1, 1);
    chk("out_bb_port", bus.out_port, 16'h00BB);
    chk("out_bb_valid", bus.out_valid, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("out_idle_valid", bus.out_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

`ifdef WB_BYPASS_EN
    cyc(0, 0, 0, 1, 1, 16'h7777, 0, 0);
    chk("bypass_we", bus.rf_we, 1);
    chk("bypass_addr", bus.rf_addr, 1);
    chk("bypass_data", bus.rf_data, 16'h7777);
`endif

    // Random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) mid_reset("rst_mid");
      cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)), 16'($urandom),
          $urandom_range(0, 2) == 0, 3'($urandom_range(0, 3)), 16'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    mid_reset("rst_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
